// File: rtl/btn_repeat_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : btn_repeat_pkg
//  Description : Shared constants for the button path (FSM encoding, widths)
//  Revision    : 1.0 - initial release
// ============================================================================
package btn_repeat_pkg;

    localparam int c_cnt_w = 16;
    localparam int c_rep_w = 8;

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_wait   = 2'd1;
    localparam logic [1:0] c_st_repeat = 2'd2;

    // Saturating increment for the repeat counter
    function automatic logic [c_rep_w-1:0] sat_inc(input logic [c_rep_w-1:0] v);
        return (v == {c_rep_w{1'b1}}) ? v : v + c_rep_w'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_repeat_if.sv
`default_nettype none
// ============================================================================
//  Module      : btn_repeat_if
//  Description : Button level in, pulse/repeat status out
//  Revision    : 1.0 - initial release
// ============================================================================
interface btn_repeat_if;
    import btn_repeat_pkg::*;

    logic               in;
    logic               pulse;
    logic               repeating;
    logic [c_rep_w-1:0] rep_cnt;

    modport master (output in, input pulse, input repeating, input rep_cnt);
    modport slave  (input in, output pulse, output repeating, output rep_cnt);

endinterface
`default_nettype wire

// File: rtl/btn_repeat.sv
`default_nettype none
// ============================================================================
//  Module      : btn_repeat
//  Description : Auto-repeat generator: one pulse on press, then after DELAY
//                cycles a pulse every PERIOD cycles while the button is held
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_repeat
    import btn_repeat_pkg::*;
#(
    parameter int unsigned DELAY  = 500,
    parameter int unsigned PERIOD = 100
) (
    input  wire logic       clk,
    input  wire logic       rst,
    btn_repeat_if.slave     bus
);

    localparam logic [c_cnt_w-1:0] c_delay_last  = c_cnt_w'(DELAY - 1);
    localparam logic [c_cnt_w-1:0] c_period_last = c_cnt_w'(PERIOD - 1);

    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_pulse;
    logic               r_repeating;
    logic [c_rep_w-1:0] r_rep_cnt;

    // Release is tested first so it wins over a coincident terminal count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_cnt       <= '0;
            r_pulse     <= 1'b0;
            r_repeating <= 1'b0;
            r_rep_cnt   <= '0;
        end else begin
            r_pulse <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (bus.in) begin
                        r_state   <= c_st_wait;
                        r_cnt     <= '0;
                        r_rep_cnt <= '0;
                        r_pulse   <= 1'b1;
                    end
                end
                c_st_wait: begin
                    if (!bus.in) begin
                        r_state <= c_st_idle;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_delay_last) begin
                        r_state     <= c_st_repeat;
                        r_repeating <= 1'b1;
                        r_cnt       <= '0;
                        r_pulse     <= 1'b1;
                        r_rep_cnt   <= sat_inc(r_rep_cnt);
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                c_st_repeat: begin
                    if (!bus.in) begin
                        r_state     <= c_st_idle;
                        r_repeating <= 1'b0;
                        r_cnt       <= '0;
                    end else if (r_cnt == c_period_last) begin
                        r_cnt     <= '0;
                        r_pulse   <= 1'b1;
                        r_rep_cnt <= sat_inc(r_rep_cnt);
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                default: begin
                    r_state     <= c_st_idle;
                    r_repeating <= 1'b0;
                    r_cnt       <= '0;
                end
            endcase
        end
    end

    assign bus.pulse     = r_pulse;
    assign bus.repeating = r_repeating;
    assign bus.rep_cnt   = r_rep_cnt;

endmodule
`default_nettype wire

// File: tb/tb_btn_repeat.sv
`default_nettype none
// ============================================================================
//  Module      : tb_btn_repeat
//  Description : Scoreboard bench for btn_repeat against a hold-time model
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_repeat;

    localparam int DELAY  = 4;
    localparam int PERIOD = 2;

    typedef struct {
        logic       pulse;
        logic       repeating;
        logic [7:0] rep_cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    btn_repeat_if bus ();

    btn_repeat #(.DELAY(DELAY), .PERIOD(PERIOD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Model: cycles the button has been held since the press (-1 = released)
    int   m_hold = -1;
    int   m_rep  = 0;

    initial bus.in = 1'b0;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    task automatic drive(input logic r, input logic i);
        exp_t e;
        @(negedge clk);
        rst    = r;
        bus.in = i;
        if (r) begin
            m_hold = -1;
            m_rep  = 0;
            e = '{pulse: 1'b0, repeating: 1'b0, rep_cnt: 8'd0};
        end else if (i) begin
            m_hold++;
            if (m_hold == 0) m_rep = 0;
            e.pulse = (m_hold == 0) ||
                      (m_hold >= DELAY && ((m_hold - DELAY) % PERIOD) == 0);
            if (e.pulse && m_hold > 0 && m_rep < 255) m_rep++;
            e.repeating = (m_hold >= DELAY);
            e.rep_cnt   = 8'(m_rep);
        end else begin
            m_hold      = -1;
            e.pulse     = 1'b0;
            e.repeating = 1'b0;
            e.rep_cnt   = 8'(m_rep);
        end
        sb_q.push_back(e);
    endtask

    task automatic hold(input int n, input logic i);
        for (int k = 0; k < n; k++) drive(1'b0, i);
    endtask

    // Monitor: one expected record per clock edge after stimulus starts
    initial begin
        exp_t e;
        logic prev_pulse;
        prev_pulse = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("pulse",     int'(bus.pulse),     int'(e.pulse));
                check("repeating", int'(bus.repeating), int'(e.repeating));
                check("rep_cnt",   int'(bus.rep_cnt),   int'(e.rep_cnt));
                if (prev_pulse) check("pulse_gap", int'(bus.pulse), 0);
                prev_pulse = bus.pulse;
            end
        end
    end

    initial begin
        logic lvl;
        // reset state
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        hold(2, 1'b0);
        // single-cycle press
        hold(1, 1'b1);
        hold(6, 1'b0);
        // held press: pulses at 1,5,7,9,11
        hold(13, 1'b1);
        hold(3, 1'b0);
        // release on the terminal-count cycle
        hold(4, 1'b1);
        hold(4, 1'b0);
        // reset mid-REPEAT with the button still held
        hold(6, 1'b1);
        drive(1'b1, 1'b1);
        hold(5, 1'b1);
        hold(3, 1'b0);
        // long hold to saturate rep_cnt
        hold(600, 1'b1);
        hold(3, 1'b0);
        hold(3, 1'b1);
        hold(2, 1'b0);
        // randomized levels with occasional reset
        lvl = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 7) == 0) lvl = ~lvl;
            drive(($urandom_range(0, 49) == 0), lvl);
        end
        hold(3, 1'b0);
        repeat (3) @(negedge clk);
        check("sb_drain", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/btn_repeat.md
BTN_REPEAT -- requirements
Module: btn_repeat

Interface
REQ-001 Parameter DELAY, 500, cycles from the first press pulse to the first repeat pulse; legal range 2..65535.
REQ-002 Parameter PERIOD, 100, cycles between consecutive repeat pulses; legal range 2..65535.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset; synchronous, active-high.
REQ-005 Port in  input  1  debounced button level from the debouncer stage; 1 = pressed.
REQ-006 Port pulse  output  1  one-cycle registered strobe per press and per auto-repeat.
REQ-007 Port repeating  output  1  registered level; high while the FSM is in REPEAT.
REQ-008 Port rep_cnt  output  8  registered count of repeat pulses since the last press; saturating.

Function
REQ-009 The FSM SHALL have three states: IDLE, WAIT, REPEAT; it SHALL hold a 16-bit cycle counter cnt.
REQ-010 IDLE with in=1 SHALL go to WAIT, set cnt=0 and rep_cnt=0, and assert pulse on the next cycle.
REQ-011 IDLE with in=0 SHALL remain in IDLE, with pulse=0.
REQ-012 WAIT with in=1 and cnt<DELAY-1 SHALL increment cnt.
REQ-013 WAIT with in=1 and cnt==DELAY-1 SHALL go to REPEAT, set cnt=0, assert pulse next cycle, and increment rep_cnt.
REQ-014 REPEAT with in=1 and cnt<PERIOD-1 SHALL increment cnt.
REQ-015 REPEAT with in=1 and cnt==PERIOD-1 SHALL set cnt=0, assert pulse next cycle, and increment rep_cnt.
REQ-016 WAIT or REPEAT with in=0 SHALL go to IDLE with cnt=0 and no pulse; release SHALL take priority over a simultaneous terminal count.
REQ-017 rep_cnt SHALL saturate at 255 and SHALL hold its value after release until the next press.
REQ-018 pulse SHALL never be high for two consecutive cycles; it SHALL be registered with one-cycle latency from the sampling edge.
REQ-019 repeating SHALL be 1 exactly in cycles where the registered state is REPEAT.
REQ-020 While in is held, pulses SHALL occur at cycles t+1, t+1+DELAY, then every PERIOD cycles, where t is the first cycle in=1 is sampled in IDLE.

Reset
REQ-021 rst=1 at a clock edge SHALL force state=IDLE, cnt=0, pulse=0, repeating=0, rep_cnt=0, overriding all other inputs.
REQ-022 Reset asserted mid-WAIT or mid-REPEAT SHALL abort the sequence with no pulse in the following cycle.
REQ-023 If in=1 in the first cycle after rst deasserts, this SHALL be treated as a new press per REQ-010.

Structure
REQ-024 State encoding (IDLE/WAIT/REPEAT) and the counter width constant (16) SHALL reside in a shared package used by the button-path blocks.
REQ-025 The block SHALL be a single module with no sub-modules; cnt and rep_cnt SHALL be inline registers.
REQ-026 All outputs SHALL be driven directly from flip-flops, with no combinational path from in to any output.

Verification (bench uses DELAY=4, PERIOD=2)
REQ-027 Drive in=1 for 1 cycle at cycle 0, then in=0 -> pulse at cycle 1 only; repeating stays 0; rep_cnt=0.
REQ-028 Hold in=1 from cycle 0 -> pulses at cycles 1, 5, 7, 9, 11; repeating=1 from cycle 5; rep_cnt=4 at cycle 12.
REQ-029 Hold in=1 from cycle 0; drop to 0 on cycle 4 (terminal-count cycle) -> no pulse at cycle 5; state returns to IDLE.
REQ-030 Hold in=1; assert rst at cycle 6 -> pulse=0, repeating=0, rep_cnt=0 at cycle 7; with in still 1 after rst drops, a new press pulse one cycle later.
REQ-031 Hold in=1 for 600 cycles -> rep_cnt reaches 255 and stays; pulses continue every 2 cycles.
